// File: rtl/irq_inj_pkg.sv
// Shared types and constants for the external-interrupt injector.
package irq_inj_pkg;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_WAIT   = 2'd1,
        CH_ASSERT = 2'd2
    } ch_state_e;

    localparam logic [31:0] DEFAULT_ACK_ADDR = 32'h0000_7F20;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

endpackage

// File: rtl/irq_inj_channel.sv
// One interrupt channel: PC-match edge detect, delay counter, fire budget
// and the IDLE/WAIT/ASSERT state machine driving a single irq line.
module irq_inj_channel
    import irq_inj_pkg::*;
#(
    parameter int unsigned DELAY_W = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [31:0]        macroscopic_pc,
    input  logic [31:0]        cfg_trig_pc,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic               ack,
    output logic               irq,
    output logic               busy
);

    ch_state_e          r_state, w_state_nxt;
    logic [DELAY_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]   r_fires, w_fires_nxt, w_fires_cur, r_count_seen;
    logic               r_match, r_init;
    logic               w_match, w_trigger, w_reload;

    assign w_match   = (macroscopic_pc & WORD_MASK) == (cfg_trig_pc & WORD_MASK);
    assign w_trigger = w_match && !r_match;

    // The budget reload is folded in combinationally so a trigger on the very
    // first edge after reset release already sees the configured count.
    assign w_reload    = (r_state == CH_IDLE) && (!r_init || (cfg_count != r_count_seen));
    assign w_fires_cur = w_reload ? cfg_count : r_fires;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= CH_IDLE;
            r_cnt        <= '0;
            r_fires      <= '0;
            r_count_seen <= '0;
            r_match      <= 1'b0;
            r_init       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fires <= w_fires_nxt;
            r_match <= w_match;
            r_init  <= 1'b1;
            if (r_state == CH_IDLE) begin
                r_count_seen <= cfg_count;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fires_nxt = w_fires_cur;
        case (r_state)
            CH_IDLE: begin
                if (w_trigger && enable && (w_fires_cur != '0)) begin
                    if (cfg_delay == '0) begin
                        w_state_nxt = CH_ASSERT;
                    end else begin
                        w_state_nxt = CH_WAIT;
                        w_cnt_nxt   = cfg_delay - 1'b1;
                    end
                end
            end
            CH_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = CH_ASSERT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            CH_ASSERT: begin
                // All-ones budget means unlimited and is never consumed.
                if (ack) begin
                    w_state_nxt = CH_IDLE;
                    if (r_fires != '1) begin
                        w_fires_nxt = r_fires - 1'b1;
                    end
                end
            end
            default: w_state_nxt = CH_IDLE;
        endcase
    end

    assign irq  = (r_state == CH_ASSERT);
    assign busy = (r_state != CH_IDLE);

endmodule

// File: rtl/irq_injector.sv
// External-interrupt stimulus generator: NUM_CH PC-triggered channels plus
// the store-to-ACK_ADDR acknowledge decode shared by all of them.
module irq_injector
    import irq_inj_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DELAY_W  = 8,
    parameter int unsigned CNT_W    = 4,
    parameter logic [31:0] ACK_ADDR = DEFAULT_ACK_ADDR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [31:0]                macroscopic_pc,
    input  logic [31:0]                m_data_addr,
    input  logic [31:0]                m_data_wdata,
    input  logic [3:0]                 m_data_byteen,
    input  logic [32*NUM_CH-1:0]       cfg_trig_pc,
    input  logic [DELAY_W*NUM_CH-1:0]  cfg_delay,
    input  logic [CNT_W*NUM_CH-1:0]    cfg_count,
    output logic [NUM_CH-1:0]          irq,
    output logic                       interrupt,
    output logic [NUM_CH-1:0]          busy
);

    logic              w_ack_hit;
    logic              w_ack_all;
    logic [NUM_CH-1:0] w_ack;

    assign w_ack_hit = (|m_data_byteen) && ((m_data_addr & WORD_MASK) == ACK_ADDR);
    // A zero data word is the plain "sw $0" handler: acknowledge every channel.
    assign w_ack_all = (m_data_wdata == '0);

    always_comb begin
        w_ack = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_ack[i] = w_ack_hit && (w_ack_all || m_data_wdata[i]);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        irq_inj_channel #(
            .DELAY_W (DELAY_W),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .enable         (enable),
            .macroscopic_pc (macroscopic_pc),
            .cfg_trig_pc    (cfg_trig_pc[32*g +: 32]),
            .cfg_delay      (cfg_delay[DELAY_W*g +: DELAY_W]),
            .cfg_count      (cfg_count[CNT_W*g +: CNT_W]),
            .ack            (w_ack[g]),
            .irq            (irq[g]),
            .busy           (busy[g])
        );
    end

    assign interrupt = |irq;

endmodule

// File: tb/tb_irq_injector.sv
// Scoreboard bench for irq_injector: each driven cycle queues the expected
// irq/busy vectors, which are popped and compared just after the clock edge.
module tb_irq_injector;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [31:0]  macroscopic_pc;
    logic [31:0]  m_data_addr;
    logic [31:0]  m_data_wdata;
    logic [3:0]   m_data_byteen;
    logic [127:0] cfg_trig_pc;
    logic [31:0]  cfg_delay;
    logic [15:0]  cfg_count;
    logic [3:0]   irq;
    logic         interrupt;
    logic [3:0]   busy;

    typedef struct {
        string      tag;
        logic [3:0] eirq;
        logic [3:0] ebusy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    irq_injector #(
        .NUM_CH   (4),
        .DELAY_W  (8),
        .CNT_W    (4),
        .ACK_ADDR (32'h0000_7F20)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .macroscopic_pc (macroscopic_pc),
        .m_data_addr    (m_data_addr),
        .m_data_wdata   (m_data_wdata),
        .m_data_byteen  (m_data_byteen),
        .cfg_trig_pc    (cfg_trig_pc),
        .cfg_delay      (cfg_delay),
        .cfg_count      (cfg_count),
        .irq            (irq),
        .interrupt      (interrupt),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] pc, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] e_irq, input logic [3:0] e_busy);
        exp_t e;
        macroscopic_pc = pc;
        m_data_byteen  = be;
        m_data_addr    = addr;
        m_data_wdata   = wd;
        exp_q.push_back('{tag: tag, eirq: e_irq, ebusy: e_busy});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({e.tag, ".irq"}, 32'(irq), 32'(e.eirq));
        chk({e.tag, ".busy"}, 32'(busy), 32'(e.ebusy));
        chk({e.tag, ".int"}, 32'(interrupt), 32'(|e.eirq));
    endtask

    task automatic run(input string tag, input logic [31:0] pc,
                       input logic [3:0] e_irq, input logic [3:0] e_busy);
        step(tag, pc, 4'h0, 32'h0, 32'h0, e_irq, e_busy);
    endtask

    task automatic ack(input string tag, input logic [31:0] pc, input logic [31:0] wd,
                       input logic [3:0] e_irq, input logic [3:0] e_busy);
        step(tag, pc, 4'hF, 32'h0000_7F20, wd, e_irq, e_busy);
    endtask

    initial begin
        reset          = 1'b0;
        enable         = 1'b1;
        macroscopic_pc = 32'h3000;
        m_data_addr    = '0;
        m_data_wdata   = '0;
        m_data_byteen  = '0;
        cfg_trig_pc    = {32'h30C0, 32'h3080, 32'h3040, 32'h301C};
        cfg_delay      = {8'd0, 8'd0, 8'd5, 8'd0};
        cfg_count      = {4'hF, 4'hF, 4'hF, 4'h1};
        #1;
        chk("rst0.irq", 32'(irq), 32'h0);
        chk("rst0.busy", 32'(busy), 32'h0);
        chk("rst0.int", 32'(interrupt), 32'h0);
        #11;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single fire, budget of one
        run("sf.idle",   32'h3000, 4'b0000, 4'b0000);
        run("sf.fire",   32'h301C, 4'b0001, 4'b0001);
        run("sf.hold",   32'h3020, 4'b0001, 4'b0001);
        ack("sf.ack",    32'h3024, 32'h0, 4'b0000, 4'b0000);
        run("sf.away",   32'h3000, 4'b0000, 4'b0000);
        run("sf.spent",  32'h301C, 4'b0000, 4'b0000);
        run("sf.after",  32'h3000, 4'b0000, 4'b0000);

        // Delay of 5, ack during WAIT ignored, enable drop mid-WAIT ignored
        run("dl.k",      32'h3040, 4'b0000, 4'b0010);
        run("dl.k1",     32'h3044, 4'b0000, 4'b0010);
        ack("dl.ackw",   32'h3048, 32'h2, 4'b0000, 4'b0010);
        enable = 1'b0;
        run("dl.k3en0",  32'h304C, 4'b0000, 4'b0010);
        run("dl.k4",     32'h3050, 4'b0000, 4'b0010);
        enable = 1'b1;
        run("dl.k5",     32'h3054, 4'b0010, 4'b0010);
        ack("dl.ack",    32'h3058, 32'h2, 4'b0000, 4'b0000);
        enable = 1'b0;
        run("en.away",   32'h3000, 4'b0000, 4'b0000);
        run("en.block",  32'h3040, 4'b0000, 4'b0000);
        enable = 1'b1;
        run("en.noedge", 32'h3044, 4'b0000, 4'b0000);
        run("en.idle",   32'h3000, 4'b0000, 4'b0000);

        // Selective ack; ch0 budget reloaded by a config change while idle
        cfg_count[3:0] = 4'h2;
        run("sa.c0",     32'h301C, 4'b0001, 4'b0001);
        run("sa.c2",     32'h3080, 4'b0101, 4'b0101);
        ack("sa.ack2",   32'h3000, 32'h4, 4'b0001, 4'b0001);
        step("sa.addr24", 32'h3000, 4'hF, 32'h0000_7F24, 32'h0, 4'b0001, 4'b0001);
        step("sa.nobe",   32'h3000, 4'h0, 32'h0000_7F20, 32'h0, 4'b0001, 4'b0001);
        step("sa.ack0",   32'h3000, 4'b0100, 32'h0000_7F22, 32'h1, 4'b0000, 4'b0000);

        // Unlimited budget: parked PC fires once, each loop-back fires again
        run("ul.fire",   32'h30C0, 4'b1000, 4'b1000);
        ack("ul.ack",    32'h30C0, 32'h8, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            run("ul.park", 32'h30C0, 4'b0000, 4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            run("ul.away",  32'h3000, 4'b0000, 4'b0000);
            run("ul.loop",  32'h30C0, 4'b1000, 4'b1000);
            ack("ul.lack",  32'h30C4, 32'h8, 4'b0000, 4'b0000);
        end

        // Collision: ack and fresh trigger edge together, ack wins
        run("co.fire",   32'h3080, 4'b0100, 4'b0100);
        run("co.away",   32'h3000, 4'b0100, 4'b0100);
        ack("co.both",   32'h3080, 32'h4, 4'b0000, 4'b0000);
        run("co.park",   32'h3080, 4'b0000, 4'b0000);
        run("co.leave",  32'h3000, 4'b0000, 4'b0000);
        run("co.refire", 32'h3080, 4'b0100, 4'b0100);
        ack("co.ack",    32'h3000, 32'h4, 4'b0000, 4'b0000);

        // Asynchronous reset mid-ASSERT, then a fresh budget of two
        run("rs.arm",    32'h301C, 4'b0001, 4'b0001);
        #2;
        reset          = 1'b0;
        macroscopic_pc = 32'h3000;
        #1;
        chk("rs.async.irq", 32'(irq), 32'h0);
        chk("rs.async.busy", 32'(busy), 32'h0);
        chk("rs.async.int", 32'(interrupt), 32'h0);
        @(posedge clk);
        #1;
        chk("rs.held.irq", 32'(irq), 32'h0);
        reset = 1'b1;
        run("rs.idle",   32'h3000, 4'b0000, 4'b0000);
        run("rs.f1",     32'h301C, 4'b0001, 4'b0001);
        ack("rs.a1",     32'h3000, 32'h0, 4'b0000, 4'b0000);
        run("rs.f2",     32'h301C, 4'b0001, 4'b0001);
        ack("rs.a2",     32'h3000, 32'h0, 4'b0000, 4'b0000);
        run("rs.spent",  32'h301C, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
